sss_seq_reader: RTL and testbench

Read-side sequencer for the SSS pattern RAM.
- Given a start request with base address, length and repeat count, it generates the RAM read address/enable stream, absorbs the RAM's 1-cycle read latency, and delivers the words as a valid/ready stream with start- and end-of-pass flags.
- Sits between the SSS pattern RAM read port (same clock as that port) and the sync correlator.

---
 rtl/sss_seq_reader.sv | 205 ++++++++++++++++++++
 tb/tb_sss_seq_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sss_seq_reader.sv
// rtl/sss_seq_reader.sv - read sequencer for the SSS pattern RAM with a 2-entry skid FIFO
// Optional descending-order reads are enabled by defining SSS_RD_REV_EN (adds irev).
module sss_seq_reader #(
    parameter int pDAT_W   = 4,
    parameter int pDAT_Num = 1024,
    parameter int pREP_W   = 4
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              istart,
    input  logic [10:0]       ibase,
    input  logic [10:0]       ilen,
    input  logic [pREP_W-1:0] irep,
`ifdef SSS_RD_REV_EN
    input  logic              irev,
`endif
    output logic [10:0]       oaddr,
    output logic              oval,
    input  logic [pDAT_W-1:0] idat,
    output logic [pDAT_W-1:0] odat,
    output logic              oval_out,
    input  logic              irdy,
    output logic              osop,
    output logic              oeop,
    output logic              obusy,
    output logic              odone,
    output logic              oerr
);

    localparam logic [10:0] ADDR_MASK = 11'(pDAT_Num - 1);
    localparam int          ENT_W     = pDAT_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [10:0]       base_q, base_d;
    logic [10:0]       len_q, len_d;
    logic [pREP_W-1:0] rep_q, rep_d;
    logic              rev_q, rev_d;
    logic [10:0]       off_q, off_d;
    logic [pREP_W-1:0] pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              inflight_q, inflight_d;
    logic              tag_sop_q, tag_sop_d;
    logic              tag_eop_q, tag_eop_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ENT_W-1:0]  mem_q [2];
    logic [ENT_W-1:0]  mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              pop;
    logic              push;
    logic [2:0]        level;
    logic              issue;
    logic              last_off;
    logic [10:0]       rd_off;
    logic [10:0]       addr_full;
    logic [ENT_W-1:0]  head;

    // Occupancy the FIFO will reach once the in-flight word lands; a read is
    // only issued when there is guaranteed room for its data.
    assign pop       = (cnt_q != 2'd0) & irdy;
    assign push      = inflight_q;
    assign level     = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == RUN) && (level <= 3'd1);
    assign last_off  = (off_q == (len_q - 11'd1));
    assign rd_off    = rev_q ? (len_q - 11'd1 - off_q) : off_q;
    assign addr_full = base_q + rd_off;

    assign oval  = issue;
    assign oaddr = issue ? (addr_full & ADDR_MASK) : 11'd0;

    assign head     = mem_q[rd_ptr_q];
    assign oval_out = (cnt_q != 2'd0);
    assign odat     = oval_out ? head[pDAT_W-1:0] : '0;
    assign osop     = oval_out & head[pDAT_W+1];
    assign oeop     = oval_out & head[pDAT_W];
    assign obusy    = busy_q;
    assign odone    = done_q;
    assign oerr     = err_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        rep_d      = rep_q;
        rev_d      = rev_q;
        off_d      = off_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        inflight_d = issue;
        tag_sop_d  = (off_q == 11'd0);
        tag_eop_d  = last_off;

        case (state_q)
            IDLE: begin
                if (istart) begin
                    if (ilen != 11'd0) begin
                        base_d  = ibase;
                        len_d   = ilen;
                        rep_d   = irep;
`ifdef SSS_RD_REV_EN
                        rev_d   = irev;
`else
                        rev_d   = 1'b0;
`endif
                        off_d   = 11'd0;
                        pass_d  = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    if (last_off) begin
                        off_d = 11'd0;
                        if (pass_q == rep_q) begin
                            state_d = DRAIN;
                        end else begin
                            pass_d = pass_q + 1'b1;
                        end
                    end else begin
                        off_d = off_q + 11'd1;
                    end
                end
            end
            DRAIN: begin
                // Finish in the cycle the final word transfers so odone lands right after it.
                if (level == 3'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {tag_sop_q, tag_eop_q, idat};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q    <= IDLE;
            base_q     <= 11'd0;
            len_q      <= 11'd0;
            rep_q      <= '0;
            rev_q      <= 1'b0;
            off_q      <= 11'd0;
            pass_q     <= '0;
            busy_q     <= 1'b0;
            inflight_q <= 1'b0;
            tag_sop_q  <= 1'b0;
            tag_eop_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            rep_q      <= rep_d;
            rev_q      <= rev_d;
            off_q      <= off_d;
            pass_q     <= pass_d;
            busy_q     <= busy_d;
            inflight_q <= inflight_d;
            tag_sop_q  <= tag_sop_d;
            tag_eop_q  <= tag_eop_d;
            done_q     <= done_d;
            err_q      <= err_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sss_seq_reader.sv
// tb/tb_sss_seq_reader.sv - directed self-checking bench for sss_seq_reader
module tb_sss_seq_reader;

    localparam int NUM = 1024;

    logic        clk = 1'b0;
    logic        irst;
    logic        istart;
    logic [10:0] ibase;
    logic [10:0] ilen;
    logic [3:0]  irep;
`ifdef SSS_RD_REV_EN
    logic        irev;
`endif
    logic [10:0] oaddr;
    logic        oval;
    logic [3:0]  idat;
    logic [3:0]  odat;
    logic        oval_out;
    logic        irdy;
    logic        osop;
    logic        oeop;
    logic        obusy;
    logic        odone;
    logic        oerr;

    sss_seq_reader #(.pDAT_W(4), .pDAT_Num(NUM), .pREP_W(4)) dut (
        .iclk(clk), .irst(irst), .istart(istart), .ibase(ibase), .ilen(ilen), .irep(irep),
`ifdef SSS_RD_REV_EN
        .irev(irev),
`endif
        .oaddr(oaddr), .oval(oval), .idat(idat), .odat(odat), .oval_out(oval_out),
        .irdy(irdy), .osop(osop), .oeop(oeop), .obusy(obusy), .odone(odone), .oerr(oerr)
    );

    always #5 clk = ~clk;

    logic [3:0] ram [NUM];
    always @(posedge clk) if (oval) idat <= ram[oaddr[9:0]];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc, first_val, done_ofs, busy_cnt, done_cnt, err_cnt, stall_bad;
    int addr_q[$];
    int wd_q[$];
    int ws_q[$];
    int we_q[$];
    logic       prev_stall;
    logic [5:0] prev_word;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (oval) addr_q.push_back(int'(oaddr));
        if (oval_out && first_val < 0) first_val = cyc - start_cyc;
        if (prev_stall && !(oval_out && {osop, oeop, odat} == prev_word)) stall_bad++;
        prev_stall = oval_out && !irdy;
        prev_word  = {osop, oeop, odat};
        if (oval_out && irdy) begin
            wd_q.push_back(int'(odat));
            ws_q.push_back(int'(osop));
            we_q.push_back(int'(oeop));
        end
        if (obusy) busy_cnt++;
        if (odone) begin
            done_cnt++;
            done_ofs = cyc - start_cyc;
        end
        if (oerr) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        addr_q.delete(); wd_q.delete(); ws_q.delete(); we_q.delete();
        first_val = -1; done_ofs = -1; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
        stall_bad = 0; prev_stall = 1'b0;
    endtask

    task automatic do_start(input int b, input int l, input int r, input logic rv);
        @(posedge clk); #1;
        ibase = 11'(b); ilen = 11'(l); irep = 4'(r);
`ifdef SSS_RD_REV_EN
        irev = rv;
`endif
        istart = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        istart = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic bp);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            if (bp) irdy = 1'($urandom_range(0, 1));
            n++;
        end
        irdy = 1'b1;
        chk("done_within_budget", 32'(done_cnt != 0), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_check(input string nm, input int b, input int l, input int r, input logic rv);
        int n = l * (r + 1);
        int ea, o;
        chk({nm, "_naddr"}, 32'(addr_q.size()), 32'(n));
        chk({nm, "_nwords"}, 32'(wd_q.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            o  = k % l;
            ea = rv ? (b + l - 1 - o) % NUM : (b + o) % NUM;
            if (k < addr_q.size()) chk($sformatf("%s_addr%0d", nm, k), 32'(addr_q[k]), 32'(ea));
            if (k < wd_q.size()) begin
                chk($sformatf("%s_dat%0d", nm, k), 32'(wd_q[k]), 32'(ram[ea]));
                chk($sformatf("%s_sop%0d", nm, k), 32'(ws_q[k]), 32'(o == 0));
                chk($sformatf("%s_eop%0d", nm, k), 32'(we_q[k]), 32'(o == l - 1));
            end
        end
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NUM; i++) ram[i] = 4'((i * 5 + 3) ^ (i >> 4));
        irst = 1'b1; istart = 1'b0; ibase = '0; ilen = '0; irep = '0; irdy = 1'b1;
`ifdef SSS_RD_REV_EN
        irev = 1'b0;
`endif
        start_cyc = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 irst = 1'b0;
        @(negedge clk);
        chk("rst_oval_out", 32'(oval_out), 32'd0);
        chk("rst_obusy", 32'(obusy), 32'd0);
        chk("rst_odone", 32'(odone), 32'd0);
        chk("rst_oerr", 32'(oerr), 32'd0);
        chk("rst_oval", 32'(oval), 32'd0);
        chk("rst_oaddr", 32'(oaddr), 32'd0);

        // basic pass
        clear_mon();
        do_start(0, 8, 0, 1'b0);
        wait_done(200, 1'b0);
        run_check("basic", 0, 8, 0, 1'b0);
        chk("basic_first_val_ofs", 32'(first_val), 32'd3);
        chk("basic_done_ofs", 32'(done_ofs), 32'd11);
        chk("basic_busy_cycles", 32'(busy_cnt), 32'd10);

        // wrap with repeats
        clear_mon();
        do_start(1020, 8, 2, 1'b0);
        wait_done(300, 1'b0);
        run_check("wrap", 1020, 8, 2, 1'b0);

        // backpressure
        clear_mon();
        do_start(200, 16, 0, 1'b0);
        wait_done(2000, 1'b1);
        run_check("bp", 200, 16, 0, 1'b0);
        chk("bp_stall_stable", 32'(stall_bad), 32'd0);

        // zero-length request rejected
        clear_mon();
        do_start(5, 0, 0, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("len0_err_cnt", 32'(err_cnt), 32'd1);
        chk("len0_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("len0_done_cnt", 32'(done_cnt), 32'd0);
        chk("len0_naddr", 32'(addr_q.size()), 32'd0);

        // single-word passes
        clear_mon();
        do_start(40, 1, 3, 1'b0);
        wait_done(200, 1'b0);
        run_check("len1", 40, 1, 3, 1'b0);

        // start while running is ignored
        clear_mon();
        do_start(0, 8, 0, 1'b0);
        @(posedge clk); #1;
        ibase = 11'd100; ilen = 11'd5; istart = 1'b1;
        @(posedge clk); #1;
        istart = 1'b0;
        wait_done(200, 1'b0);
        run_check("busy_start", 0, 8, 0, 1'b0);

        // reset mid-pass
        clear_mon();
        do_start(0, 16, 0, 1'b0);
        begin
            int n = 0;
            while (wd_q.size() < 5 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_mid_reached5", 32'(wd_q.size() >= 5), 32'd1);
        @(posedge clk); #1 irst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_oval_out", 32'(oval_out), 32'd0);
        chk("rst_mid_obusy", 32'(obusy), 32'd0);
        #1 irst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
        clear_mon();
        do_start(0, 4, 0, 1'b0);
        wait_done(200, 1'b0);
        run_check("after_rst", 0, 4, 0, 1'b0);

`ifdef SSS_RD_REV_EN
        clear_mon();
        do_start(10, 4, 0, 1'b1);
        wait_done(200, 1'b0);
        run_check("rev", 10, 4, 0, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
